// File: rtl/led_pkg.sv
// Constants and helpers shared between the step controller and the LED pattern generator.
package led_pkg;

   localparam int MODE_W  = 2;
   localparam int SPEED_W = 2;

   localparam logic [MODE_W-1:0] MODE_FILL_UP  = 2'b00;
   localparam logic [MODE_W-1:0] MODE_DRAIN_UP = 2'b01;
   localparam logic [MODE_W-1:0] MODE_DRAIN_DN = 2'b10;
   localparam logic [MODE_W-1:0] MODE_FILL_DN  = 2'b11;

   // Step period for a speed index: each speed step halves the base period (shift only).
   function automatic int unsigned step_period(input int unsigned div,
                                               input logic [SPEED_W-1:0] speed);
      return div >> speed;
   endfunction

endpackage

// File: rtl/led_step_ctrl_if.sv
// Button inputs and generator-facing outputs of the step controller, plus debounced levels.
interface led_step_ctrl_if;
   import led_pkg::*;

   logic               BTN_MODE;
   logic               BTN_RUN;
   logic               BTN_FAST;
   logic               SS;
   logic [MODE_W-1:0]  MODE;
   logic               RUN;
   logic [SPEED_W-1:0] SPEED;
   // Debounced button levels {fast, run, mode}, observation only.
   logic [2:0]         btn_level;

   modport master (
      input  BTN_MODE, BTN_RUN, BTN_FAST,
      output SS, MODE, RUN, SPEED, btn_level
   );

   modport slave (
      output BTN_MODE, BTN_RUN, BTN_FAST,
      input  SS, MODE, RUN, SPEED, btn_level
   );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one raw push-button; emits a one-cycle pulse on each accepted press.
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic Clk,
   input  logic RST,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge Clk or posedge RST) begin
      if (RST) begin
         sync_q  <= 2'b00;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw};
         level_d <= level;
         press   <= level & ~level_d;
         // Any sample agreeing with the accepted level restarts the stability window.
         if (sync_q[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_q[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_step_ctrl.sv
// Button front-end for the LED pattern generator: mode/run/speed registers and the step divider.
module led_step_ctrl
   import led_pkg::*;
#(
   parameter int STEP_DIV   = 25_000_000,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic           Clk,
   input  logic           RST,
   led_step_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(STEP_DIV);

   logic               press_mode, press_run, press_fast;
   logic               level_mode, level_run, level_fast;
   logic               any_event;
   logic [MODE_W-1:0]  mode_q;
   logic               run_q;
   logic [SPEED_W-1:0] speed_q;
   logic               ss_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_last;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .Clk(Clk), .RST(RST), .btn_raw(bus.BTN_MODE), .level(level_mode), .press(press_mode)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
      .Clk(Clk), .RST(RST), .btn_raw(bus.BTN_RUN), .level(level_run), .press(press_run)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_fast (
      .Clk(Clk), .RST(RST), .btn_raw(bus.BTN_FAST), .level(level_fast), .press(press_fast)
   );

   assign any_event = press_mode | press_run | press_fast;
   assign cnt_last  = CNT_W'(step_period(STEP_DIV, speed_q) - 1);

   always_ff @(posedge Clk or posedge RST) begin
      if (RST) begin
         mode_q  <= MODE_FILL_UP;
         run_q   <= 1'b0;
         speed_q <= '0;
      end else begin
         if (press_mode) mode_q  <= mode_q + 1'b1;
         if (press_run)  run_q   <= ~run_q;
         if (press_fast) speed_q <= speed_q + 1'b1;
      end
   end

   // Every press restarts the period so the generator never sees a stale strobe.
   always_ff @(posedge Clk or posedge RST) begin
      if (RST) begin
         cnt  <= '0;
         ss_q <= 1'b0;
      end else if (any_event || !run_q) begin
         cnt  <= '0;
         ss_q <= 1'b0;
      end else if (cnt == cnt_last) begin
         cnt  <= '0;
         ss_q <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         ss_q <= 1'b0;
      end
   end

   assign bus.SS        = ss_q;
   assign bus.MODE      = mode_q;
   assign bus.RUN       = run_q;
   assign bus.SPEED     = speed_q;
   assign bus.btn_level = {level_fast, level_run, level_mode};

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with STEP_DIV=16 and DEB_CYCLES=4.
module tb_led_step_ctrl;
   import led_pkg::*;

   localparam int STEP_DIV   = 16;
   localparam int DEB_CYCLES = 4;
   localparam int B_MODE = 0;
   localparam int B_RUN  = 1;
   localparam int B_FAST = 2;

   logic Clk;
   logic RST;
   int   checks;
   int   failures;

   led_step_ctrl_if bus ();

   led_step_ctrl #(.STEP_DIV(STEP_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
      .Clk(Clk), .RST(RST), .bus(bus.master)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         B_MODE:  bus.BTN_MODE = v;
         B_RUN:   bus.BTN_RUN  = v;
         default: bus.BTN_FAST = v;
      endcase
   endtask

   // Returns just after the edge on which the register update lands (raw rise + 8 edges).
   task automatic press_btn(input int which);
      set_btn(which, 1'b1);
      step(8);
      set_btn(which, 1'b0);
   endtask

   // Expects SS low for p-1 cycles and high on the p-th.
   task automatic ss_gap(input int p, input string tag);
      for (int i = 1; i < p; i++) begin
         step(1);
         chk({tag, "_lo"}, {31'd0, bus.SS}, 32'd0);
      end
      step(1);
      chk({tag, "_hi"}, {31'd0, bus.SS}, 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ss"},    {31'd0, bus.SS},    32'd0);
      chk({tag, "_mode"},  {30'd0, bus.MODE},  32'd0);
      chk({tag, "_run"},   {31'd0, bus.RUN},   32'd0);
      chk({tag, "_speed"}, {30'd0, bus.SPEED}, 32'd0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      RST          = 1'b1;
      bus.BTN_MODE = 1'b0;
      bus.BTN_RUN  = 1'b0;
      bus.BTN_FAST = 1'b0;

      step(3);
      chk_all_zero("reset");
      RST = 1'b0;
      step(4);
      chk_all_zero("post_reset");

      // run start: RUN lands 7 edges after the first edge seeing the press
      set_btn(B_RUN, 1'b1);
      step(7);
      chk("run_before", {31'd0, bus.RUN}, 32'd0);
      step(1);
      chk("run_set", {31'd0, bus.RUN}, 32'd1);
      set_btn(B_RUN, 1'b0);
      ss_gap(16, "run_ss1");
      ss_gap(16, "run_ss2");
      ss_gap(16, "run_ss3");

      // speed sweep
      press_btn(B_FAST);
      chk("speed1", {30'd0, bus.SPEED}, 32'd1);
      ss_gap(8, "p8a");
      ss_gap(8, "p8b");
      press_btn(B_FAST);
      chk("speed2", {30'd0, bus.SPEED}, 32'd2);
      ss_gap(4, "p4a");
      ss_gap(4, "p4b");
      press_btn(B_FAST);
      chk("speed3", {30'd0, bus.SPEED}, 32'd3);
      for (int i = 0; i < 4; i++) ss_gap(2, "p2");
      press_btn(B_FAST);
      chk("speed_wrap", {30'd0, bus.SPEED}, 32'd0);
      ss_gap(16, "p16");

      // mode wrap
      press_btn(B_MODE);
      chk("mode1", {30'd0, bus.MODE}, 32'd1);
      ss_gap(16, "mode1_gap");
      press_btn(B_MODE);
      chk("mode2", {30'd0, bus.MODE}, 32'd2);
      ss_gap(16, "mode2_gap");
      press_btn(B_MODE);
      chk("mode3", {30'd0, bus.MODE}, 32'd3);
      ss_gap(16, "mode3_gap");
      press_btn(B_MODE);
      chk("mode_wrap", {30'd0, bus.MODE}, 32'd0);
      ss_gap(16, "mode0_gap");

      // bounce: short pulses are rejected, the final hold counts once
      for (int i = 0; i < 3; i++) begin
         set_btn(B_MODE, 1'b1);
         step(3);
         set_btn(B_MODE, 1'b0);
         step(2);
      end
      chk("bounce_reject", {30'd0, bus.MODE}, 32'd0);
      set_btn(B_MODE, 1'b1);
      step(7);
      chk("bounce_before", {30'd0, bus.MODE}, 32'd0);
      step(1);
      chk("bounce_once", {30'd0, bus.MODE}, 32'd1);
      step(6);
      set_btn(B_MODE, 1'b0);
      step(10);
      chk("bounce_after", {30'd0, bus.MODE}, 32'd1);

      // reset mid-run with MODE=2, SPEED=1
      press_btn(B_MODE);
      ss_gap(16, "pre_rst_mode");
      press_btn(B_FAST);
      ss_gap(8, "pre_rst_fast");
      chk("pre_rst_mode", {30'd0, bus.MODE}, 32'd2);
      chk("pre_rst_speed", {30'd0, bus.SPEED}, 32'd1);
      chk("pre_rst_run", {31'd0, bus.RUN}, 32'd1);
      step(3);
      #3;
      RST = 1'b1;
      #1;
      chk_all_zero("async_rst");
      step(2);
      chk_all_zero("in_rst");
      RST = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         chk("rst_no_ss", {31'd0, bus.SS}, 32'd0);
      end
      chk_all_zero("after_rst");

      // simultaneous RUN + FAST from paused, SPEED=0
      set_btn(B_RUN, 1'b1);
      set_btn(B_FAST, 1'b1);
      step(7);
      chk("sim_run_before", {31'd0, bus.RUN}, 32'd0);
      chk("sim_speed_before", {30'd0, bus.SPEED}, 32'd0);
      step(1);
      chk("sim_run", {31'd0, bus.RUN}, 32'd1);
      chk("sim_speed", {30'd0, bus.SPEED}, 32'd1);
      set_btn(B_RUN, 1'b0);
      set_btn(B_FAST, 1'b0);
      ss_gap(8, "sim_ss1");
      ss_gap(8, "sim_ss2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
